// File: rtl/ddr2_sdram_local_arbiter.sv
// Two-master arbiter for the DDR2 controller local interface; in-order owner tags route write-data and read returns.
// Define DDR2_ARB_PORT0_PRIORITY_EN for strict port-0 priority (default build is round-robin).
module ddr2_sdram_local_arbiter #(
  parameter int TAG_DEPTH = 8,
  parameter int TAG_AW    = 3
) (
  input  logic         phy_clk,
  input  logic         reset_phy_clk_n,
  input  logic [45:0]  m_address,
  input  logic [1:0]   m_read_req,
  input  logic [1:0]   m_write_req,
  input  logic [127:0] m_wdata,
  input  logic [15:0]  m_be,
  output logic [1:0]   m_ready,
  output logic [1:0]   m_wdata_req,
  output logic [63:0]  m_rdata,
  output logic [1:0]   m_rdata_valid,
  output logic [22:0]  local_address,
  output logic         local_read_req,
  output logic         local_write_req,
  output logic         local_burstbegin,
  output logic         local_size,
  output logic [63:0]  local_wdata,
  output logic [7:0]   local_be,
  input  logic         local_ready,
  input  logic         local_wdata_req,
  input  logic         local_rdata_valid,
  input  logic         local_init_done,
  input  logic [63:0]  local_rdata,
  output logic         arb_error
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_e;

  localparam logic [TAG_AW-1:0] PTR_ONE  = TAG_AW'(1);
  localparam logic [TAG_AW:0]   CNT_ZERO = (TAG_AW+1)'(0);
  localparam logic [TAG_AW:0]   CNT_FULL = (TAG_AW+1)'(TAG_DEPTH);

  state_e            state_q, state_d;
  logic              grant_id_q, grant_id_d;
  logic              last_grant_q, last_grant_d;
  logic              is_read_q, is_read_d;
  logic              err_q, err_d;
  logic [22:0]       addr_q, addr_d;

  logic              rf_mem_q [TAG_DEPTH];
  logic              wf_mem_q [TAG_DEPTH];
  logic [TAG_AW-1:0] rf_wp_q, rf_wp_d, rf_rp_q, rf_rp_d;
  logic [TAG_AW-1:0] wf_wp_q, wf_wp_d, wf_rp_q, wf_rp_d;
  logic [TAG_AW:0]   rf_cnt_q, rf_cnt_d, wf_cnt_q, wf_cnt_d;

  logic [1:0]        elig_s;
  logic              win_s, accept_s, both_err_s;
  logic              rf_push_s, rf_pop_s, wf_push_s, wf_pop_s;
  logic              rf_empty_s, wf_empty_s, rf_head_s, wf_head_s;

  // Per-port eligibility: a port asking for both read and write is treated as a read.
  always_comb begin
    elig_s = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (!local_init_done) elig_s[p] = 1'b0;
      else if (m_read_req[p]) elig_s[p] = (rf_cnt_q != CNT_FULL);
      else if (m_write_req[p]) elig_s[p] = (wf_cnt_q != CNT_FULL);
      else elig_s[p] = 1'b0;
    end
  end

  // Winner selection among eligible ports.
  always_comb begin
    win_s = 1'b0;
`ifdef DDR2_ARB_PORT0_PRIORITY_EN
    if (elig_s[0]) win_s = 1'b0;
    else win_s = 1'b1;
`else
    if (elig_s[0] && elig_s[1]) win_s = ~last_grant_q;
    else if (elig_s[0]) win_s = 1'b0;
    else win_s = 1'b1;
`endif
  end

  // Next-state logic for the command FSM and grant bookkeeping.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    is_read_d    = is_read_q;
    addr_d       = addr_q;
    both_err_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|elig_s) begin
          state_d    = S_ISSUE;
          grant_id_d = win_s;
          is_read_d  = m_read_req[win_s];
          addr_d     = win_s ? m_address[45:23] : m_address[22:0];
          both_err_s = m_read_req[win_s] & m_write_req[win_s];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (local_ready) begin
          state_d      = S_IDLE;
          last_grant_d = grant_id_q;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Owner-tag FIFO pointers; strobes against an empty FIFO flag an error instead of popping.
  always_comb begin
    accept_s   = (state_q == S_ISSUE) && local_ready;
    rf_empty_s = (rf_cnt_q == CNT_ZERO);
    wf_empty_s = (wf_cnt_q == CNT_ZERO);
    rf_head_s  = rf_mem_q[rf_rp_q];
    wf_head_s  = wf_mem_q[wf_rp_q];
    rf_push_s  = accept_s & is_read_q;
    wf_push_s  = accept_s & ~is_read_q;
    rf_pop_s   = local_rdata_valid & ~rf_empty_s;
    wf_pop_s   = local_wdata_req & ~wf_empty_s;
    rf_wp_d    = rf_push_s ? rf_wp_q + PTR_ONE : rf_wp_q;
    wf_wp_d    = wf_push_s ? wf_wp_q + PTR_ONE : wf_wp_q;
    rf_rp_d    = rf_pop_s ? rf_rp_q + PTR_ONE : rf_rp_q;
    wf_rp_d    = wf_pop_s ? wf_rp_q + PTR_ONE : wf_rp_q;
    rf_cnt_d   = rf_cnt_q + (TAG_AW+1)'(rf_push_s) - (TAG_AW+1)'(rf_pop_s);
    wf_cnt_d   = wf_cnt_q + (TAG_AW+1)'(wf_push_s) - (TAG_AW+1)'(wf_pop_s);
    err_d      = err_q | both_err_s | (local_rdata_valid & rf_empty_s) | (local_wdata_req & wf_empty_s);
  end

  // Output decode from registered state and the tag FIFO heads.
  always_comb begin
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    if (state_q == S_ISSUE) begin
      local_read_req   = is_read_q;
      local_write_req  = ~is_read_q;
      local_burstbegin = 1'b1;
    end else begin
      local_burstbegin = 1'b0;
    end
    local_address = addr_q;
    local_size    = 1'b1;
    arb_error     = err_q;
    m_ready       = accept_s ? (grant_id_q ? 2'b10 : 2'b01) : 2'b00;
    m_rdata       = local_rdata;
    m_rdata_valid = rf_pop_s ? (rf_head_s ? 2'b10 : 2'b01) : 2'b00;
    m_wdata_req   = wf_pop_s ? (wf_head_s ? 2'b10 : 2'b01) : 2'b00;
    if (wf_empty_s) begin
      local_wdata = 64'h0;
      local_be    = 8'h00;
    end else begin
      local_wdata = wf_head_s ? m_wdata[127:64] : m_wdata[63:0];
      local_be    = wf_head_s ? m_be[15:8] : m_be[7:0];
    end
  end

  // State and pointer registers; last_grant resets to 1 so port 0 wins first.
  always_ff @(posedge phy_clk) begin
    if (!reset_phy_clk_n) begin
      state_q      <= S_IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      is_read_q    <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 23'h0;
      rf_wp_q      <= PTR_ONE - PTR_ONE;
      rf_rp_q      <= PTR_ONE - PTR_ONE;
      wf_wp_q      <= PTR_ONE - PTR_ONE;
      wf_rp_q      <= PTR_ONE - PTR_ONE;
      rf_cnt_q     <= CNT_ZERO;
      wf_cnt_q     <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      is_read_q    <= is_read_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      rf_wp_q      <= rf_wp_d;
      rf_rp_q      <= rf_rp_d;
      wf_wp_q      <= wf_wp_d;
      wf_rp_q      <= wf_rp_d;
      rf_cnt_q     <= rf_cnt_d;
      wf_cnt_q     <= wf_cnt_d;
    end
  end

  // Tag storage; contents are don't-care until pointed to, so no reset.
  always_ff @(posedge phy_clk) begin
    if (rf_push_s) rf_mem_q[rf_wp_q] <= grant_id_q;
    if (wf_push_s) wf_mem_q[wf_wp_q] <= grant_id_q;
  end

endmodule
